// File: rtl/chorus_scheduler.sv
// Four-tap cascaded chorus sequencer: time-multiplexes one shared delay engine
// over four serial passes per sample, with bypass, overrun and timeout supervision.
module chorus_scheduler #(
  parameter logic [4:0]  TAP0    = 5'd3,
  parameter logic [4:0]  TAP1    = 5'd7,
  parameter logic [4:0]  TAP2    = 5'd15,
  parameter logic [4:0]  TAP3    = 5'd31,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               enable,
  input  logic signed [11:0] incoming_sample,
  output logic signed [11:0] modified_sample,
  output logic               done,
  output logic               busy,
  output logic               eng_start,
  output logic [1:0]         eng_tap,
  output logic [4:0]         eng_delay_amount,
  output logic signed [11:0] eng_sample,
  input  logic signed [11:0] eng_result,
  input  logic               eng_done,
  output logic               overrun,
  output logic               timeout_err
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_e;

  state_e             state_q;
  logic [1:0]         pass_q;
  logic [1:0]         pass_d;
  logic [CW-1:0]      cnt_q;
  logic signed [11:0] in_q;
  logic signed [11:0] mod_q;
  logic signed [11:0] eng_sample_q;
  logic               done_q, busy_q, eng_start_q, overrun_q, timeout_err_q;
  logic [1:0]         eng_tap_q;
  logic [4:0]         eng_delay_q;

  function automatic logic [4:0] tap_amount(input logic [1:0] p);
    case (p)
      2'd0:    return TAP0;
      2'd1:    return TAP1;
      2'd2:    return TAP2;
      default: return TAP3;
    endcase
  endfunction

  always_comb begin
    pass_d = pass_q + 2'd1;
  end

  // eng_sample_q doubles as the cascade working register: it always holds the
  // input of the pass currently in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pass_q        <= '0;
      cnt_q         <= '0;
      in_q          <= '0;
      mod_q         <= '0;
      eng_sample_q  <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      eng_start_q   <= 1'b0;
      eng_tap_q     <= '0;
      eng_delay_q   <= '0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      eng_start_q <= 1'b0;
      if (start && state_q != S_IDLE) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            in_q   <= incoming_sample;
            busy_q <= 1'b1;
            if (enable) begin
              pass_q       <= '0;
              eng_tap_q    <= '0;
              eng_delay_q  <= TAP0;
              eng_sample_q <= incoming_sample;
              eng_start_q  <= 1'b1;
              state_q      <= S_ISSUE;
            end else begin
              mod_q   <= incoming_sample;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_done) begin
            eng_sample_q <= eng_result;
            if (pass_q != 2'd3) begin
              pass_q      <= pass_d;
              eng_tap_q   <= pass_d;
              eng_delay_q <= tap_amount(pass_d);
              eng_start_q <= 1'b1;
              state_q     <= S_ISSUE;
            end else begin
              mod_q   <= eng_result;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            // Engine hung: fall back to the dry input sample.
            mod_q         <= in_q;
            timeout_err_q <= 1'b1;
            done_q        <= 1'b1;
            state_q       <= S_FINISH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign modified_sample  = mod_q;
  assign done             = done_q;
  assign busy             = busy_q;
  assign eng_start        = eng_start_q;
  assign eng_tap          = eng_tap_q;
  assign eng_delay_amount = eng_delay_q;
  assign eng_sample       = eng_sample_q;
  assign overrun          = overrun_q;
  assign timeout_err      = timeout_err_q;

endmodule

// File: doc/chorus_scheduler.md
# chorus_scheduler

Sequencer that runs the four-tap chorus (30/70/150/310 ms taps, cascaded) on one shared delay engine instead of four parallel delay instances. Per sample-rate `start` it issues four serial passes to the engine, feeding each pass's result into the next. It then presents the final sample with a one-cycle `done`. It sits between the audio sample source and the effect output mux, and also supervises the engine with overrun and timeout detection.

## Interface
- `TAP0`, default 5'd3: `eng_delay_amount` for pass 0 (30 ms)
- `TAP1`, default 5'd7: pass 1 (70 ms)
- `TAP2`, default 5'd15: pass 2 (150 ms)
- `TAP3`, default 5'd31: pass 3 (310 ms)
- `TIMEOUT`, default 1024: max cycles to wait for `eng_done` per pass (≥2)

- `clock` in 1: system clock
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle sample strobe
- `enable` in 1: 1 = apply chorus, 0 = bypass; sampled only with an accepted `start`
- `incoming_sample` in 12 signed: input sample, valid with `start`
- `modified_sample` out 12 signed: result, registered, held until next update
- `done` out 1: one-cycle pulse, result valid
- `busy` out 1: high in every state except IDLE
- `eng_start` out 1: one-cycle pass request to the engine
- `eng_tap` out 2: pass index; selects the engine's buffer region
- `eng_delay_amount` out 5: TAPn for the current pass
- `eng_sample` out 12 signed: pass input, stable from the ISSUE cycle until `eng_done`
- `eng_result` in 12 signed: engine output, valid with `eng_done`
- `eng_done` in 1: one-cycle engine completion
- `overrun` out 1: sticky; set when `start` arrives outside IDLE
- `timeout_err` out 1: sticky; set on a pass timeout

## Operation
- States and transitions:
  - **IDLE**: on `start`, latch `incoming_sample` into `in_reg` and `work`, latch `enable`.
    - `enable`=1: clear pass to 0, go to ISSUE.
    - `enable`=0: set `modified_sample` from `incoming_sample`, go to FINISH.
  - **ISSUE**: `eng_start`=1; `eng_tap`=pass; `eng_delay_amount`=TAP[pass]; `eng_sample`=`work`; clear the timeout counter; go to WAIT.
  - **WAIT**:
    - On `eng_done`: `work`←`eng_result`. If pass<3, pass++ and go to ISSUE. Otherwise `modified_sample`←`eng_result` and go to FINISH.
    - If the counter reaches TIMEOUT−1 with no `eng_done`: `modified_sample`←`in_reg` (dry fallback), set `timeout_err`, go to FINISH.
  - **FINISH**: `done`=1; go to IDLE.
- Input rules:
  - A `start` in ISSUE, WAIT or FINISH is ignored and sets `overrun`. The in-flight sample is unaffected.
  - `eng_done` outside WAIT is ignored.
  - `enable` changes mid-operation have no effect.
- Arithmetic: none. Samples pass through unchanged in width, 12-bit signed. Saturation is the engine's job.
- Sticky flags clear only on reset.

## Timing
- Reset (`reset`=0, async), all of the following immediately:
  - state IDLE, pass 0
  - `modified_sample`, `done`, `busy`, `eng_start`, `eng_tap`, `eng_delay_amount`, `eng_sample` = 0
  - `overrun`=0, `timeout_err`=0
- Reset mid-operation abandons the sample; no `done` is produced. Deassertion takes effect at the next clock edge.
- Cycle numbering for an engine with latency L (`eng_done` L cycles after `eng_start`, L≥1), `start` sampled in cycle 0:
  - pass k `eng_start` in cycle 1+k(L+1)
  - final `eng_done` in cycle 4L+4
  - `done` and the new `modified_sample` in cycle 4L+5
  - IDLE in cycle 4L+6, where the next `start` is accepted
- Bypass: `done` in cycle 1, IDLE in cycle 2.
- Timeout: `done` fires TIMEOUT+1 cycles after the failing pass's `eng_start`.
- `eng_start` is never high in two consecutive cycles.

## Test plan
- Nominal: engine model with L=10 and `eng_result` = input+1. `start` with sample 100, `enable`=1.
  - `eng_start` in cycles 1, 12, 23, 34.
  - `eng_tap` 0..3; `eng_delay_amount` 3, 7, 15, 31.
  - `eng_sample` 100, 101, 102, 103.
  - `done` in cycle 45 with `modified_sample`=104.
- Bypass: `enable`=0, sample −2048 → `done` in cycle 1 with `modified_sample`=−2048, no `eng_start`.
- Overrun: second `start` (sample 7) in cycle 5 of nominal → `overrun`=1; result still 104 in cycle 45.
- Back-to-back: new `start` in cycle 46 (IDLE) → accepted, `eng_start` in cycle 47, `overrun` stays 0.
- Timeout: TIMEOUT=16, engine never responds to pass 1, sample 55 → `done` in cycle 29 with `modified_sample`=55 and `timeout_err`=1.
  - A later spurious `eng_done` in IDLE has no effect.
- Reset: assert `reset`=0 in cycle 20 of nominal → all outputs 0 immediately.
  - After release, no `done` appears.
  - A fresh `start` runs the nominal sequence.
